// File: rtl/between_pkg.sv
// Shared types and constants for the between_to_in receiver.
package between_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam int BETWEEN_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/between_fifo.sv
// First-word-fall-through byte FIFO; DEPTH must be a power of two (>= 2).
module between_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_LEVEL);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = count_q;
  assign dout    = empty ? 8'h00 : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = AW'(wr_ptr_q + 1);
    if (do_pop)  rd_ptr_d = AW'(rd_ptr_q + 1);
    case ({do_push, do_pop})
      2'b10:   count_d = CW'(count_q + 1);
      2'b01:   count_d = CW'(count_q - 1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: dout is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/between_to_in.sv
// Strobe/acknowledge byte receiver feeding a FWFT FIFO.
// Optional BETWEEN_SYNC_EN inserts a 2-flop synchronizer on tsent.
module between_to_in
  import between_pkg::*;
#(
  parameter int DEPTH = BETWEEN_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   t0,
  input  logic                   t1,
  input  logic                   t2,
  input  logic                   t3,
  input  logic                   t4,
  input  logic                   t5,
  input  logic                   t6,
  input  logic                   t7,
  input  logic                   tsent,
  output logic                   trecieve,
  output logic [7:0]             data,
  output logic                   isValid,
  input  logic                   isTake,
  output logic [$clog2(DEPTH):0] level
);

  logic       tsent_i;
  state_t     state_q, state_d;
  logic       trecieve_q, trecieve_d;
  logic       push, pop, full, empty;
  logic [7:0] byte_in;

`ifdef BETWEEN_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], tsent};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign tsent_i = sync_q[1];
`else
  assign tsent_i = tsent;
`endif

  // Data lines are held stable by the sender while tsent is high.
  assign byte_in = {t7, t6, t5, t4, t3, t2, t1, t0};

  always_comb begin
    state_d    = state_q;
    trecieve_d = trecieve_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (tsent_i && !full) begin
          push       = 1'b1;
          trecieve_d = 1'b1;
          state_d    = ACK;
        end
      end
      ACK: begin
        if (!tsent_i) begin
          trecieve_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        trecieve_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      trecieve_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      trecieve_q <= trecieve_d;
    end
  end

  assign pop      = isTake && !empty;
  assign isValid  = !empty;
  assign trecieve = trecieve_q;

  between_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (byte_in),
    .pop   (pop),
    .dout  (data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule
